// File: rtl/dct_pkg.sv
// Shared widths, cosine ROM, state encoding and the round/saturate helper
// for the 8x8 row-column inverse DCT.
package dct_pkg;

    localparam int COEF_IN_W = 12;
    localparam int SAMP_W    = 9;
    localparam int INTER_W   = 16;
    localparam int COS_FRAC  = 13;
    localparam int COS_W     = 16;
    localparam int ACC_W     = 36;
    localparam int PROD_W    = 2 * COS_W;
    localparam int N         = 8;
    localparam int NEL       = N * N;

    // Half an LSB of the final result, added before the arithmetic shift.
    localparam logic signed [ACC_W-1:0] ROUND_K = ACC_W'(64'd1 << (COS_FRAC - 1));
    localparam logic signed [ACC_W-1:0] ACC_ONE = ACC_W'(64'd1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS1 = 2'd1,
        PASS2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // C[k][n] = round(2^13 * c(k)/2 * cos((2n+1)k*pi/16)), c(0) = 1/sqrt2.
    localparam logic signed [COS_W-1:0] COS_ROM [N][N] = '{
        '{ 16'sd2896,  16'sd2896,  16'sd2896,  16'sd2896,  16'sd2896,  16'sd2896,  16'sd2896,  16'sd2896},
        '{ 16'sd4017,  16'sd3406,  16'sd2276,  16'sd799,  -16'sd799,  -16'sd2276, -16'sd3406, -16'sd4017},
        '{ 16'sd3784,  16'sd1567, -16'sd1567, -16'sd3784, -16'sd3784, -16'sd1567,  16'sd1567,  16'sd3784},
        '{ 16'sd3406, -16'sd799,  -16'sd4017, -16'sd2276,  16'sd2276,  16'sd4017,  16'sd799,  -16'sd3406},
        '{ 16'sd2896, -16'sd2896, -16'sd2896,  16'sd2896,  16'sd2896, -16'sd2896, -16'sd2896,  16'sd2896},
        '{ 16'sd2276, -16'sd4017,  16'sd799,   16'sd3406, -16'sd3406, -16'sd799,   16'sd4017, -16'sd2276},
        '{ 16'sd1567, -16'sd3784,  16'sd3784, -16'sd1567, -16'sd1567,  16'sd3784, -16'sd3784,  16'sd1567},
        '{ 16'sd799,  -16'sd2276,  16'sd3406, -16'sd4017,  16'sd4017, -16'sd3406,  16'sd2276, -16'sd799 }
    };

    // Round half up (floor on negatives), then clamp to a signed w-bit range.
    // The clamped value is returned sign-extended to INTER_W bits.
    function automatic logic signed [INTER_W-1:0] round_sat(
        input logic signed [ACC_W-1:0] v,
        input int unsigned             w
    );
        logic signed [ACC_W-1:0] r;
        logic signed [ACC_W-1:0] hi;
        logic signed [ACC_W-1:0] lo;
        r  = (v + ROUND_K) >>> COS_FRAC;
        hi = (ACC_ONE <<< (w - 1)) - ACC_ONE;
        lo = -(ACC_ONE <<< (w - 1));
        if (r > hi) begin
            r = hi;
        end else if (r < lo) begin
            r = lo;
        end
        return r[INTER_W-1:0];
    endfunction

endpackage

// File: rtl/idct_mac_unit.sv
// Single multiply-accumulate lane shared by both IDCT passes. The final
// dot-product term is folded into the rounded result in the same cycle.
module idct_mac_unit
    import dct_pkg::*;
#(
    parameter int OUT_W = INTER_W
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    i_en,
    input  logic                    i_clear,
    input  logic                    i_last,
    input  logic                    i_narrow,
    input  logic signed [COS_W-1:0] i_coef,
    input  logic signed [COS_W-1:0] i_data,
    output logic signed [OUT_W-1:0] o_result,
    output logic                    o_wr
);

    logic signed [ACC_W-1:0]   r_acc;
    logic signed [PROD_W-1:0]  w_product;
    logic signed [ACC_W-1:0]   w_prod_ext;
    logic signed [ACC_W-1:0]   w_sum;
    logic signed [INTER_W-1:0] w_full;

    assign w_product  = i_coef * i_data;
    assign w_prod_ext = {{(ACC_W - PROD_W){w_product[PROD_W-1]}}, w_product};
    // A clear restarts the sum at this cycle's product rather than adding to stale state.
    assign w_sum      = (i_clear ? '0 : r_acc) + w_prod_ext;
    // Pass 2 narrows to sample width; pass 1 keeps the wider intermediate.
    assign w_full     = round_sat(w_sum, i_narrow ? SAMP_W : OUT_W);
    assign o_result   = w_full[OUT_W-1:0];
    assign o_wr       = i_en & i_last;

    // Accumulator register: holds the running partial sum between MAC cycles.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum;
        end
    end

endmodule

// File: rtl/two_d_idct.sv
// 8x8 two-dimensional inverse DCT, row-column order, one MAC per cycle.
// Pass 1 builds T[u][n] from the coefficient rows, pass 2 builds X[m][n]
// from the columns of T. Handshake: IN_START is taken only in IDLE,
// OUT_BUSY covers the whole job, OUT_XFC pulses once when OUT_X is final.
module two_d_idct
    import dct_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      IN_START,
    input  logic [NEL*COEF_IN_W-1:0]  IN_Y,
    output logic [NEL*SAMP_W-1:0]     OUT_X,
    output logic                      OUT_XFC,
    output logic                      OUT_BUSY
);

    state_t                     r_state;
    logic [5:0]                 r_o;
    logic [2:0]                 r_k;
    logic                       r_busy;
    logic                       r_xfc;
    logic signed [COEF_IN_W-1:0] r_y [NEL];
    logic signed [INTER_W-1:0]  r_t [NEL];
    logic signed [SAMP_W-1:0]   r_x [NEL];

    logic signed [COS_W-1:0]    w_coef;
    logic signed [COS_W-1:0]    w_data;
    logic                       w_en;
    logic                       w_clear;
    logic                       w_last;
    logic                       w_narrow;
    logic signed [INTER_W-1:0]  w_result;
    logic                       w_wr;
    logic [5:0]                 w_y_idx;
    logic [5:0]                 w_t_idx;

    assign w_en     = (r_state == PASS1) || (r_state == PASS2);
    assign w_clear  = (r_k == 3'd0);
    assign w_last   = (r_k == 3'd7);
    assign w_narrow = (r_state == PASS2);
    assign w_y_idx  = {r_o[5:3], r_k};
    assign w_t_idx  = {r_k, r_o[2:0]};

    // Operand select: pass 1 walks row u of Y, pass 2 walks column n of T.
    always_comb begin
        w_coef = '0;
        w_data = '0;
        case (r_state)
            PASS1: begin
                w_coef = COS_ROM[r_k][r_o[2:0]];
                w_data = {{(COS_W - COEF_IN_W){r_y[w_y_idx][COEF_IN_W-1]}}, r_y[w_y_idx]};
            end
            PASS2: begin
                w_coef = COS_ROM[r_k][r_o[5:3]];
                w_data = r_t[w_t_idx];
            end
            default: begin
                w_coef = '0;
                w_data = '0;
            end
        endcase
    end

    idct_mac_unit #(
        .OUT_W (INTER_W)
    ) u_mac (
        .clock    (clock),
        .reset    (reset),
        .i_en     (w_en),
        .i_clear  (w_clear),
        .i_last   (w_last),
        .i_narrow (w_narrow),
        .i_coef   (w_coef),
        .i_data   (w_data),
        .o_result (w_result),
        .o_wr     (w_wr)
    );

    // Block FSM with counters, coefficient latch, T buffer and OUT_X holding register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= IDLE;
            r_o     <= '0;
            r_k     <= '0;
            r_busy  <= 1'b0;
            r_xfc   <= 1'b0;
            for (int i = 0; i < NEL; i++) begin
                r_y[i] <= '0;
                r_t[i] <= '0;
                r_x[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    r_xfc <= 1'b0;
                    if (IN_START) begin
                        for (int i = 0; i < NEL; i++) begin
                            r_y[i] <= IN_Y[i*COEF_IN_W +: COEF_IN_W];
                        end
                        r_o     <= '0;
                        r_k     <= '0;
                        r_busy  <= 1'b1;
                        r_state <= PASS1;
                    end
                end
                PASS1: begin
                    r_k <= r_k + 3'd1;
                    if (w_wr) begin
                        r_t[r_o] <= w_result;
                        r_o      <= r_o + 6'd1;
                        if (r_o == 6'd63) begin
                            r_state <= PASS2;
                        end
                    end
                end
                PASS2: begin
                    r_k <= r_k + 3'd1;
                    if (w_wr) begin
                        r_x[r_o] <= w_result[SAMP_W-1:0];
                        r_o      <= r_o + 6'd1;
                        if (r_o == 6'd63) begin
                            r_xfc   <= 1'b1;
                            r_state <= DONE;
                        end
                    end
                end
                DONE: begin
                    r_xfc   <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NEL; g++) begin : g_out
        assign OUT_X[g*SAMP_W +: SAMP_W] = r_x[g];
    end

    assign OUT_XFC  = r_xfc;
    assign OUT_BUSY = r_busy;

endmodule

// File: tb/tb_two_d_idct.sv
// Directed bench for two_d_idct: reset state, DC blocks, saturation,
// a horizontal AC block, ignored re-start, and reset abort.
module tb_two_d_idct;

    localparam int CW  = 12;
    localparam int SW  = 9;
    localparam int NE  = 64;
    localparam int LAT = 1025;
    localparam int MAXC = 1100;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               IN_START = 1'b0;
    logic [NE*CW-1:0]   IN_Y = '0;
    logic [NE*SW-1:0]   OUT_X;
    logic               OUT_XFC;
    logic               OUT_BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clock = ~clock;

    two_d_idct dut (
        .clock    (clock),
        .reset    (reset),
        .IN_START (IN_START),
        .IN_Y     (IN_Y),
        .OUT_X    (OUT_X),
        .OUT_XFC  (OUT_XFC),
        .OUT_BUSY (OUT_BUSY)
    );

    function automatic logic [NE*CW-1:0] y_single(input int idx, input int val);
        logic [NE*CW-1:0] y;
        logic [CW-1:0]    e;
        y = '0;
        e = CW'(val);
        y[idx*CW +: CW] = e;
        return y;
    endfunction

    function automatic logic [NE*SW-1:0] x_fill(input int val);
        logic [NE*SW-1:0] x;
        logic [SW-1:0]    e;
        e = SW'(val);
        for (int i = 0; i < NE; i++) x[i*SW +: SW] = e;
        return x;
    endfunction

    // Expected block for Y[0][1] = 100: each row is 17,15,10,4,-4,-10,-15,-17.
    function automatic logic [NE*SW-1:0] x_ac_row();
        logic [NE*SW-1:0] x;
        int pat [8];
        pat = '{17, 15, 10, 4, -4, -10, -15, -17};
        for (int m = 0; m < 8; m++)
            for (int n = 0; n < 8; n++)
                x[(m*8+n)*SW +: SW] = SW'(pat[n]);
        return x;
    endfunction

    // Pulse START with y, then step until XFC or the cycle budget runs out.
    task automatic run_block(input logic [NE*CW-1:0] y, output int lat, output int busy_low);
        @(posedge clock); #1;
        IN_Y = y;
        IN_START = 1'b1;
        @(posedge clock); #1;
        IN_START = 1'b0;
        lat = 1;
        busy_low = 0;
        while (1) begin
            if (!OUT_BUSY) busy_low++;
            if (OUT_XFC || lat >= MAXC) break;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        n_checks++;
        if (OUT_X !== '0) begin
            n_fail++; $display("FAIL reset_out_x: got %h expected 0", OUT_X);
        end
        n_checks++;
        if (OUT_XFC !== 1'b0) begin
            n_fail++; $display("FAIL reset_xfc: got %b expected 0", OUT_XFC);
        end
        n_checks++;
        if (OUT_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b expected 0", OUT_BUSY);
        end
        reset = 1'b0;
    endtask

    task automatic test_zero();
        int lat, bl;
        run_block('0, lat, bl);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL zero_latency: got %0d expected %0d", lat, LAT);
        end
        n_checks++;
        if (bl !== 0) begin
            n_fail++; $display("FAIL zero_busy_span: got %0d low cycles expected 0", bl);
        end
        n_checks++;
        if (OUT_X !== '0) begin
            n_fail++; $display("FAIL zero_out_x: got %h expected 0", OUT_X);
        end
        @(posedge clock); #1;
        n_checks++;
        if (OUT_XFC !== 1'b0 || OUT_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL zero_after_done: got xfc=%b busy=%b expected 0 0", OUT_XFC, OUT_BUSY);
        end
    endtask

    // Single DC coefficient: every sample takes the same value.
    task automatic test_dc(input string name, input int dc, input int exp_val);
        int lat, bl;
        logic [NE*SW-1:0] exp_x;
        exp_x = x_fill(exp_val);
        run_block(y_single(0, dc), lat, bl);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL %s_latency: got %0d expected %0d", name, lat, LAT);
        end
        n_checks++;
        if (OUT_X !== exp_x) begin
            n_fail++; $display("FAIL %s_out_x: got %h expected %h", name, OUT_X, exp_x);
        end
    endtask

    task automatic test_ac();
        int lat, bl;
        logic [NE*SW-1:0] exp_x;
        exp_x = x_ac_row();
        run_block(y_single(1, 100), lat, bl);
        n_checks++;
        if (lat !== LAT) begin
            n_fail++; $display("FAIL ac_latency: got %0d expected %0d", lat, LAT);
        end
        n_checks++;
        if (OUT_X !== exp_x) begin
            n_fail++; $display("FAIL ac_out_x: got %h expected %h", OUT_X, exp_x);
        end
    endtask

    // First block zeroes OUT_X; the AC block then runs with a START pulse at cycle 300.
    task automatic test_restart_ignored();
        int lat, bl, cyc, n_xfc, first_xfc;
        logic [NE*SW-1:0] exp_x;
        exp_x = x_ac_row();
        run_block('0, lat, bl);
        @(posedge clock); #1;
        IN_Y = y_single(1, 100);
        IN_START = 1'b1;
        @(posedge clock); #1;
        IN_START = 1'b0;
        n_xfc = 0;
        first_xfc = 0;
        for (cyc = 1; cyc <= MAXC; cyc++) begin
            if (cyc == 300) begin
                IN_Y = y_single(0, 2047);
                IN_START = 1'b1;
            end else begin
                IN_START = 1'b0;
            end
            if (OUT_XFC) begin
                n_xfc++;
                if (first_xfc == 0) first_xfc = cyc;
            end
            @(posedge clock); #1;
        end
        IN_START = 1'b0;
        n_checks++;
        if (n_xfc !== 1) begin
            n_fail++; $display("FAIL restart_xfc_count: got %0d expected 1", n_xfc);
        end
        n_checks++;
        if (first_xfc !== LAT) begin
            n_fail++; $display("FAIL restart_xfc_cycle: got %0d expected %0d", first_xfc, LAT);
        end
        n_checks++;
        if (OUT_X !== exp_x) begin
            n_fail++; $display("FAIL restart_out_x: got %h expected %h", OUT_X, exp_x);
        end
    endtask

    task automatic test_reset_abort();
        int lat, bl, cyc, n_xfc, n_busy;
        // Reset and START together: reset wins, nothing starts.
        @(posedge clock); #1;
        reset = 1'b1;
        IN_START = 1'b1;
        IN_Y = y_single(0, 64);
        @(posedge clock); #1;
        reset = 1'b0;
        IN_START = 1'b0;
        @(posedge clock); #1;
        n_checks++;
        if (OUT_BUSY !== 1'b0) begin
            n_fail++; $display("FAIL reset_start_busy: got %b expected 0", OUT_BUSY);
        end
        // Abort during pass 2 after a block that left OUT_X non-zero.
        run_block(y_single(0, 2047), lat, bl);
        @(posedge clock); #1;
        IN_Y = y_single(0, -64);
        IN_START = 1'b1;
        @(posedge clock); #1;
        IN_START = 1'b0;
        cyc = 1;
        while (cyc < 600) begin
            @(posedge clock); #1;
            cyc++;
        end
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        n_checks++;
        if (OUT_X !== '0) begin
            n_fail++; $display("FAIL abort_out_x: got %h expected 0", OUT_X);
        end
        n_checks++;
        if (OUT_BUSY !== 1'b0 || OUT_XFC !== 1'b0) begin
            n_fail++; $display("FAIL abort_flags: got busy=%b xfc=%b expected 0 0", OUT_BUSY, OUT_XFC);
        end
        n_xfc = 0;
        n_busy = 0;
        for (int i = 0; i < MAXC; i++) begin
            if (OUT_XFC) n_xfc++;
            if (OUT_BUSY) n_busy++;
            @(posedge clock); #1;
        end
        n_checks++;
        if (n_xfc !== 0 || n_busy !== 0) begin
            n_fail++; $display("FAIL abort_quiet: got xfc=%0d busy=%0d cycles expected 0 0", n_xfc, n_busy);
        end
        test_dc("post_abort", 64, 8);
    endtask

    initial begin
        test_reset();
        test_zero();
        test_dc("dc_pos64", 64, 8);
        test_dc("dc_neg64", -64, -8);
        test_dc("dc_sat2047", 2047, 255);
        test_dc("dc_neg2048", -2048, -256);
        test_ac();
        test_restart_ignored();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
